// File: rtl/ghost_move_ctrl_pkg.sv
// ============================================================================
// Module      : ghost_move_ctrl_pkg
// Description : Shared game encodings: travel directions, grid defaults and
//               the ghost movement FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ghost_move_ctrl_pkg;

    localparam logic [2:0] STAY  = 3'd0;
    localparam logic [2:0] RIGHT = 3'd1;
    localparam logic [2:0] LEFT  = 3'd2;
    localparam logic [2:0] UP    = 3'd3;
    localparam logic [2:0] DOWN  = 3'd4;

    localparam int GRID_X_MAX      = 19;
    localparam int GRID_Y_MAX      = 14;
    localparam int GRID_HOME_X     = 9;
    localparam int GRID_HOME_Y     = 7;
    localparam int ACK_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRY_REQ   = 3'd1,
        WAIT_REQ  = 3'd2,
        TRY_PREV  = 3'd3,
        WAIT_PREV = 3'd4,
        COMMIT    = 3'd5,
        HOME      = 3'd6
    } ghost_state_t;

endpackage

`default_nettype wire

// File: rtl/ghost_move_ctrl_grid_step.sv
// ============================================================================
// Module      : grid_step
// Description : Neighbour cell of (x,y) in direction dir, flagged offgrid when
//               it leaves the playfield or the direction code is invalid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_step
    import ghost_move_ctrl_pkg::*;
#(
    parameter int X_MAX = GRID_X_MAX,
    parameter int Y_MAX = GRID_Y_MAX
) (
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [2:0] dir,
    output logic [4:0] nx,
    output logic [4:0] ny,
    output logic       offgrid
);

    localparam logic signed [5:0] XM = 6'(X_MAX);
    localparam logic signed [5:0] YM = 6'(Y_MAX);

    logic signed [5:0] sx;
    logic signed [5:0] sy;
    logic signed [5:0] tx;
    logic signed [5:0] ty;
    logic              bad_dir;

    always_comb begin
        sx      = signed'({1'b0, x});
        sy      = signed'({1'b0, y});
        tx      = sx;
        ty      = sy;
        bad_dir = 1'b0;
        case (dir)
            RIGHT:   tx = sx + 6'sd1;
            LEFT:    tx = sx - 6'sd1;
            UP:      ty = sy - 6'sd1;
            DOWN:    ty = sy + 6'sd1;
            STAY:    ;
            default: bad_dir = 1'b1;
        endcase
        offgrid = bad_dir || (tx < 6'sd0) || (tx > XM) || (ty < 6'sd0) || (ty > YM);
        // Hold the current cell when blocked so the outputs stay in range.
        nx = offgrid ? x : tx[4:0];
        ny = offgrid ? y : ty[4:0];
    end

endmodule

`default_nettype wire

// File: rtl/ghost_move_ctrl.sv
// ============================================================================
// Module      : ghost_move_ctrl
// Description : Ghost movement FSM: requested move, momentum fallback, maze
//               wall lookups with timeout, and catch/return-home handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghost_move_ctrl
    import ghost_move_ctrl_pkg::*;
#(
    parameter int X_MAX       = GRID_X_MAX,
    parameter int Y_MAX       = GRID_Y_MAX,
    parameter int START_X     = GRID_HOME_X,
    parameter int START_Y     = GRID_HOME_Y,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_tick,
    input  logic [2:0] req_dir,
    input  logic [4:0] pac_x,
    input  logic [4:0] pac_y,
    output logic       wall_req,
    output logic [4:0] wall_x,
    output logic [4:0] wall_y,
    input  logic       wall_ack,
    input  logic       wall_blocked,
    output logic [4:0] ghost_x,
    output logic [4:0] ghost_y,
    output logic [2:0] ghost_dir,
    output logic       move_done,
    output logic       caught
);

    localparam int            CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    ghost_state_t  state_q, state_d;
    logic [2:0]    cand_q, cand_d, gdir_q, gdir_d, mdir_q, mdir_d;
    logic [4:0]    gx_q, gx_d, gy_q, gy_d;
    logic [4:0]    wx_q, wx_d, wy_q, wy_d;
    logic [4:0]    mx_q, mx_d, my_q, my_d;
    logic          req_q, req_d, done_q, done_d, caught_q, caught_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0] w_step_dir;
    logic [4:0] w_nx, w_ny;
    logic       w_offgrid;
    logic       w_resolved;
    logic       w_blk;

    assign w_step_dir = (state_q == TRY_REQ) ? cand_q : gdir_q;

    grid_step #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_grid_step (
        .x       (gx_q),
        .y       (gy_q),
        .dir     (w_step_dir),
        .nx      (w_nx),
        .ny      (w_ny),
        .offgrid (w_offgrid)
    );

    // A dropped request (timeout) resolves the wait as blocked.
    assign w_resolved = !req_q || wall_ack;
    assign w_blk      = !req_q || wall_blocked;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        gdir_d   = gdir_q;
        mdir_d   = mdir_q;
        gx_d     = gx_q;
        gy_d     = gy_q;
        wx_d     = wx_q;
        wy_d     = wy_q;
        mx_d     = mx_q;
        my_d     = my_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        caught_d = 1'b0;

        if (state_q == WAIT_REQ || state_q == WAIT_PREV) begin
            if (req_q) begin
                if (wall_ack || cnt_q == CNT_LAST) begin
                    req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (move_tick) begin
                    cand_d  = req_dir;
                    state_d = (req_dir == STAY) ? TRY_PREV : TRY_REQ;
                end
            end
            TRY_REQ: begin
                if (w_offgrid) begin
                    state_d = TRY_PREV;
                end else begin
                    wx_d    = w_nx;
                    wy_d    = w_ny;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_REQ;
                end
            end
            WAIT_REQ: begin
                if (w_resolved) begin
                    if (w_blk) begin
                        state_d = TRY_PREV;
                    end else begin
                        mx_d    = wx_q;
                        my_d    = wy_q;
                        mdir_d  = cand_q;
                        state_d = COMMIT;
                    end
                end
            end
            TRY_PREV: begin
                if (gdir_q == STAY || gdir_q == cand_q || w_offgrid) begin
                    mx_d    = gx_q;
                    my_d    = gy_q;
                    mdir_d  = STAY;
                    state_d = COMMIT;
                end else begin
                    wx_d    = w_nx;
                    wy_d    = w_ny;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_PREV;
                end
            end
            WAIT_PREV: begin
                if (w_resolved) begin
                    mx_d    = w_blk ? gx_q : wx_q;
                    my_d    = w_blk ? gy_q : wy_q;
                    mdir_d  = w_blk ? STAY : gdir_q;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (mx_q == pac_x && my_q == pac_y) begin
                    state_d = HOME;
                end else begin
                    gx_d    = mx_q;
                    gy_d    = my_q;
                    gdir_d  = mdir_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            HOME: begin
                gx_d     = 5'(START_X);
                gy_d     = 5'(START_Y);
                gdir_d   = STAY;
                done_d   = 1'b1;
                caught_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cand_q   <= STAY;
            gdir_q   <= STAY;
            mdir_q   <= STAY;
            gx_q     <= 5'(START_X);
            gy_q     <= 5'(START_Y);
            wx_q     <= '0;
            wy_q     <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            req_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            caught_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            gdir_q   <= gdir_d;
            mdir_q   <= mdir_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            caught_q <= caught_d;
        end
    end

    assign wall_req  = req_q;
    assign wall_x    = wx_q;
    assign wall_y    = wy_q;
    assign ghost_x   = gx_q;
    assign ghost_y   = gy_q;
    assign ghost_dir = gdir_q;
    assign move_done = done_q;
    assign caught    = caught_q;

endmodule

`default_nettype wire

// File: tb/tb_ghost_move_ctrl.sv
// ============================================================================
// Module      : tb_ghost_move_ctrl
// Description : Directed self-checking bench for ghost_move_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ghost_move_ctrl;
    import ghost_move_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       move_tick = 1'b0;
    logic [2:0] req_dir = STAY;
    logic [4:0] pac_x = 5'd31;
    logic [4:0] pac_y = 5'd31;
    logic       wall_ack = 1'b0;
    logic       wall_blocked = 1'b0;
    logic       wall_req;
    logic [4:0] wall_x, wall_y, ghost_x, ghost_y;
    logic [2:0] ghost_dir;
    logic       move_done, caught;

    ghost_move_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .move_tick    (move_tick),
        .req_dir      (req_dir),
        .pac_x        (pac_x),
        .pac_y        (pac_y),
        .wall_req     (wall_req),
        .wall_x       (wall_x),
        .wall_y       (wall_y),
        .wall_ack     (wall_ack),
        .wall_blocked (wall_blocked),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .ghost_dir    (ghost_dir),
        .move_done    (move_done),
        .caught       (caught)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int lx[2];
    int ly[2];
    int lat, nreq, reqhi, cgt;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Pulses move_tick, answers each lookup with b0 then b1, and records
    // latency (cycles from the tick cycle to move_done) and lookup activity.
    task automatic do_move(input logic [2:0] d, input logic b0, input logic b1,
                           input bit ack_en);
        bit prev;
        bit done;
        @(negedge clk);
        move_tick = 1'b1;
        req_dir   = d;
        lat = 0; nreq = 0; reqhi = 0; cgt = 0; prev = 1'b0; done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk);
            move_tick    = 1'b0;
            lat++;
            wall_ack     = 1'b0;
            wall_blocked = 1'b0;
            if (move_done) begin
                done = 1'b1;
                cgt  = int'(caught);
            end else if (wall_req) begin
                reqhi++;
                if (!prev) begin
                    if (nreq < 2) begin
                        lx[nreq] = int'(wall_x);
                        ly[nreq] = int'(wall_y);
                    end
                    nreq++;
                end
                if (ack_en) begin
                    wall_ack     = 1'b1;
                    wall_blocked = (nreq == 1) ? b0 : b1;
                end
            end
            prev = wall_req;
        end
        chk("move_done_seen", int'(done), 1);
        @(negedge clk);
        chk("move_done_one_cycle", int'(move_done), 0);
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey, input int ed);
        chk({tag, "_x"}, int'(ghost_x), ex);
        chk({tag, "_y"}, int'(ghost_y), ey);
        chk({tag, "_dir"}, int'(ghost_dir), ed);
    endtask

    initial begin
        int k;
        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_pos("reset", 9, 7, 0);
        chk("reset_wall_req", int'(wall_req), 0);
        chk("reset_move_done", int'(move_done), 0);
        chk("reset_caught", int'(caught), 0);
        reset = 1'b1;

        // Clear right move: 4-cycle latency, lookup at (10,7)
        do_move(RIGHT, 1'b0, 1'b0, 1'b1);
        chk("clear_lat", lat, 4);
        chk("clear_nreq", nreq, 1);
        chk("clear_lx", lx[0], 10);
        chk("clear_ly", ly[0], 7);
        chk("clear_caught", cgt, 0);
        chk_pos("clear", 10, 7, 1);

        // Walk to (9,7) heading right: left, left, right
        do_move(LEFT, 1'b0, 1'b0, 1'b1);
        do_move(LEFT, 1'b0, 1'b0, 1'b1);
        chk_pos("walk_left", 8, 7, 2);
        do_move(RIGHT, 1'b0, 1'b0, 1'b1);
        chk_pos("walk_right", 9, 7, 1);

        // Blocked up turn falls back to momentum
        do_move(UP, 1'b1, 1'b0, 1'b1);
        chk("turn_nreq", nreq, 2);
        chk("turn_lx0", lx[0], 9);
        chk("turn_ly0", ly[0], 6);
        chk("turn_lx1", lx[1], 10);
        chk("turn_ly1", ly[1], 7);
        chk("turn_lat", lat, 6);
        chk_pos("turn", 10, 7, 1);

        // Both lookups time out: no move, direction cleared
        do_move(UP, 1'b0, 1'b0, 1'b0);
        chk("timeout_nreq", nreq, 2);
        chk("timeout_req_cycles", reqhi, 30);
        chk("timeout_lat", lat, 36);
        chk_pos("timeout", 10, 7, 0);

        // Stationary request with no momentum
        do_move(STAY, 1'b0, 1'b0, 1'b1);
        chk("stay_nreq", nreq, 0);
        chk("stay_lat", lat, 3);
        chk_pos("stay", 10, 7, 0);

        // Walk to (0,5)
        do_move(UP, 1'b0, 1'b0, 1'b1);
        do_move(UP, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) do_move(LEFT, 1'b0, 1'b0, 1'b1);
        chk_pos("edge_walk", 0, 5, 2);

        // Left edge: off-grid, momentum equals request
        do_move(LEFT, 1'b0, 1'b0, 1'b1);
        chk("edge1_nreq", nreq, 0);
        chk("edge1_lat", lat, 4);
        chk_pos("edge1", 0, 5, 0);
        do_move(LEFT, 1'b0, 1'b0, 1'b1);
        chk("edge2_nreq", nreq, 0);
        chk_pos("edge2", 0, 5, 0);

        // Left edge with downward momentum falls back to (0,7)
        do_move(DOWN, 1'b0, 1'b0, 1'b1);
        chk_pos("edge_down", 0, 6, 4);
        do_move(LEFT, 1'b0, 1'b0, 1'b1);
        chk("edge3_nreq", nreq, 1);
        chk("edge3_lx", lx[0], 0);
        chk("edge3_ly", ly[0], 7);
        chk("edge3_lat", lat, 5);
        chk_pos("edge3", 0, 7, 4);

        // Reset back home, then catch Pacman at (10,7)
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_pos("reset2", 9, 7, 0);
        reset = 1'b1;
        pac_x = 5'd10;
        pac_y = 5'd7;
        do_move(RIGHT, 1'b0, 1'b0, 1'b1);
        chk("catch_caught", cgt, 1);
        chk("catch_lat", lat, 5);
        chk_pos("catch", 9, 7, 0);
        pac_x = 5'd31;
        pac_y = 5'd31;

        // Reset during WAIT_REQ abandons the lookup
        do_move(RIGHT, 1'b0, 1'b0, 1'b1);
        chk_pos("pre_abort", 10, 7, 1);
        @(negedge clk);
        move_tick = 1'b1;
        req_dir   = UP;
        @(negedge clk);
        move_tick = 1'b0;
        k = 0;
        while (!wall_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("abort_req_seen", int'(wall_req), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_wall_req", int'(wall_req), 0);
        chk_pos("abort", 9, 7, 0);
        reset        = 1'b1;
        wall_ack     = 1'b1;
        wall_blocked = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_no_done", int'(move_done), 0);
        end
        wall_ack = 1'b0;
        chk_pos("late_ack", 9, 7, 0);
        do_move(RIGHT, 1'b0, 1'b0, 1'b1);
        chk("fresh_lat", lat, 4);
        chk_pos("fresh", 10, 7, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
